// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset and ordered core/peripheral reset release; optional PLL_RESET_SEQUENCER_LOSS_FILTER_EN lock-loss filter
module pll_reset_sequencer #(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 1000000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int STAGE_GAP_CYCLES    = 256,
    parameter int LOSS_FILTER_CYCLES  = 8,
    parameter int CNT_W               = 20
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    input  logic       usr_rst_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       periph_rst,
    output logic       ready,
    output logic       lock_lost,
    output logic [7:0] retries
);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_REL_SYS,
        S_RUN,
        S_USR_HOLD
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lk;
    logic                   loss;
    logic                   pll_rst_q, pll_rst_d;
    logic                   sys_rst_q, sys_rst_d;
    logic                   periph_rst_q, periph_rst_d;
    logic                   ready_q, ready_d;
    logic                   lock_lost_q, lock_lost_d;
    logic [7:0]             retries_q, retries_d;

    assign lk = sync_q[SYNC_STAGES-1];

`ifdef PLL_RESET_SEQUENCER_LOSS_FILTER_EN
    logic [CNT_W-1:0] filt_q, filt_d;
    logic             filt_active;

    assign filt_active = (state_q == S_REL_SYS) || (state_q == S_RUN) || (state_q == S_USR_HOLD);
    assign filt_d      = (filt_active && !lk) ? filt_q + CNT_W'(1) : '0;
    assign loss        = !lk && (filt_q == CNT_W'(LOSS_FILTER_CYCLES - 1));
`else
    logic unused_loss_filter;

    assign unused_loss_filter = ^LOSS_FILTER_CYCLES;
    assign loss               = !lk;
`endif

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q      <= S_PLL_RST;
            cnt_q        <= '0;
            sync_q       <= '0;
            pll_rst_q    <= 1'b1;
            sys_rst_q    <= 1'b1;
            periph_rst_q <= 1'b1;
            ready_q      <= 1'b0;
            lock_lost_q  <= 1'b0;
            retries_q    <= 8'd0;
`ifdef PLL_RESET_SEQUENCER_LOSS_FILTER_EN
            filt_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sync_q       <= {sync_q[SYNC_STAGES-2:0], locked};
            pll_rst_q    <= pll_rst_d;
            sys_rst_q    <= sys_rst_d;
            periph_rst_q <= periph_rst_d;
            ready_q      <= ready_d;
            lock_lost_q  <= lock_lost_d;
            retries_q    <= retries_d;
`ifdef PLL_RESET_SEQUENCER_LOSS_FILTER_EN
            filt_q       <= filt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        lock_lost_d = lock_lost_q;
        retries_d   = retries_q;
        case (state_q)
            S_PLL_RST: begin
                if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lk) begin
                    state_d = S_STABLE;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    state_d = S_PLL_RST;
                    if (retries_q != 8'hFF) retries_d = retries_q + 8'd1;
                end
            end
            // The lk sample that left WAIT_LOCK is the first of the stable run.
            S_STABLE: begin
                if (!lk) state_d = S_WAIT_LOCK;
                else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 2)) state_d = S_REL_SYS;
            end
            S_REL_SYS: begin
                if (loss) begin
                    state_d     = S_PLL_RST;
                    lock_lost_d = 1'b1;
                end else if (usr_rst_req) begin
                    state_d = S_USR_HOLD;
                end else if (cnt_q == CNT_W'(STAGE_GAP_CYCLES - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (loss) begin
                    state_d     = S_PLL_RST;
                    lock_lost_d = 1'b1;
                end else if (usr_rst_req) begin
                    state_d = S_USR_HOLD;
                end
            end
            S_USR_HOLD: begin
                if (loss) begin
                    state_d     = S_PLL_RST;
                    lock_lost_d = 1'b1;
                end else if (!usr_rst_req) begin
                    state_d = S_REL_SYS;
                end
            end
            default: state_d = S_PLL_RST;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Decoding from the next state lines output changes up with state entry.
    always_comb begin
        pll_rst_d    = (state_d == S_PLL_RST);
        sys_rst_d    = !((state_d == S_REL_SYS) || (state_d == S_RUN));
        periph_rst_d = (state_d != S_RUN);
        ready_d      = (state_d == S_RUN);
    end

    assign pll_rst    = pll_rst_q;
    assign sys_rst    = sys_rst_q;
    assign periph_rst = periph_rst_q;
    assign ready      = ready_q;
    assign lock_lost  = lock_lost_q;
    assign retries    = retries_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - self-checking bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

    localparam int SS  = 2;
    localparam int PRC = 4;
    localparam int LTO = 50;
    localparam int LSC = 10;
    localparam int SGC = 5;
    localparam int LFC = 3;
`ifdef PLL_RESET_SEQUENCER_LOSS_FILTER_EN
    localparam int LOSS_LAT = 2 + LFC;
`else
    localparam int LOSS_LAT = 3;
`endif

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic       usr_rst_req = 1'b0;
    logic       pll_rst, sys_rst, periph_rst, ready, lock_lost;
    logic [7:0] retries;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES(SS), .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT_CYCLES(LTO),
        .LOCK_STABLE_CYCLES(LSC), .STAGE_GAP_CYCLES(SGC), .LOSS_FILTER_CYCLES(LFC), .CNT_W(20)
    ) dut (
        .refclk(refclk), .rst(rst), .locked(locked), .usr_rst_req(usr_rst_req),
        .pll_rst(pll_rst), .sys_rst(sys_rst), .periph_rst(periph_rst),
        .ready(ready), .lock_lost(lock_lost), .retries(retries)
    );

    always #10 refclk = ~refclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endtask

    // Phase model: timing kept as absolute entry timestamps rather than counters.
    typedef enum int {P_PLLRST, P_WAIT, P_STABLE, P_SYS, P_RUN, P_HOLD} phase_t;
    phase_t ph = P_PLLRST;
    int     t_enter = 0;
    int     t_rise = 0;
    int     low_run = 0;
    int     m_retries = 0;
    bit     m_lost = 1'b0;
    bit     mvalid = 1'b0;
    bit     lkq[$];
    bit     l, loss, filtered;

    task automatic enter(input phase_t p);
        ph      = p;
        t_enter = cyc;
    endtask

    always @(posedge refclk) begin
        cyc++;
        if (rst) begin
            ph = P_PLLRST; t_enter = cyc; m_lost = 0; m_retries = 0; low_run = 0;
            lkq = {};
            repeat (SS) lkq.push_back(1'b0);
            mvalid = 1'b1;
        end else if (mvalid) begin
            l        = lkq[SS-1];
            filtered = (ph == P_SYS) || (ph == P_RUN) || (ph == P_HOLD);
            low_run  = (filtered && !l) ? low_run + 1 : 0;
`ifdef PLL_RESET_SEQUENCER_LOSS_FILTER_EN
            loss = (low_run >= LFC);
`else
            loss = !l;
`endif
            case (ph)
                P_PLLRST: if (cyc - t_enter == PRC) enter(P_WAIT);
                P_WAIT: begin
                    if (l) begin
                        t_rise = cyc - 1;
                        enter(P_STABLE);
                    end else if (cyc - t_enter == LTO) begin
                        if (m_retries < 255) m_retries++;
                        enter(P_PLLRST);
                    end
                end
                P_STABLE: begin
                    if (!l) enter(P_WAIT);
                    else if (cyc - t_rise == LSC) enter(P_SYS);
                end
                P_SYS: begin
                    if (loss) begin m_lost = 1; enter(P_PLLRST); end
                    else if (usr_rst_req) enter(P_HOLD);
                    else if (cyc - t_enter == SGC) enter(P_RUN);
                end
                P_RUN: begin
                    if (loss) begin m_lost = 1; enter(P_PLLRST); end
                    else if (usr_rst_req) enter(P_HOLD);
                end
                P_HOLD: begin
                    if (loss) begin m_lost = 1; enter(P_PLLRST); end
                    else if (!usr_rst_req) enter(P_SYS);
                end
                default: enter(P_PLLRST);
            endcase
            lkq.push_front(locked);
            void'(lkq.pop_back());
        end
    end

    always @(negedge refclk) begin
        if (mvalid) begin
            cmp("model_pll_rst", {31'd0, pll_rst}, {31'd0, ph == P_PLLRST});
            cmp("model_sys_rst", {31'd0, sys_rst}, {31'd0, !(ph == P_SYS || ph == P_RUN)});
            cmp("model_periph_rst", {31'd0, periph_rst}, {31'd0, ph != P_RUN});
            cmp("model_ready", {31'd0, ready}, {31'd0, ph == P_RUN});
            cmp("model_lock_lost", {31'd0, lock_lost}, {31'd0, m_lost});
            cmp("model_retries", {24'd0, retries}, m_retries);
        end
    end

    function automatic logic sel(input int w);
        case (w)
            0:       return pll_rst;
            1:       return sys_rst;
            2:       return periph_rst;
            default: return ready;
        endcase
    endfunction

    task automatic wait_level(input int which, input logic val, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge refclk);
            if (sel(which) === val) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            total++;
            bad++;
            $display("FAIL wait_sig%0d timeout: got no level %0d within %0d cycles", which, val, budget);
        end
    endtask

    initial begin
        int   t_k, t_a, t_b;
        int   rises[$];
        logic prev;

        // Clean bring-up
        repeat (3) @(negedge refclk);
        cmp("rst_pll_rst", {31'd0, pll_rst}, 1);
        cmp("rst_sys_rst", {31'd0, sys_rst}, 1);
        cmp("rst_periph_rst", {31'd0, periph_rst}, 1);
        cmp("rst_ready", {31'd0, ready}, 0);
        cmp("rst_lock_lost", {31'd0, lock_lost}, 0);
        cmp("rst_retries", {24'd0, retries}, 0);
        rst = 1'b0;
        t_k = cyc;
        wait_level(0, 1'b0, 20, t_a);
        cmp("bringup_pll_rst_width", t_a - t_k, PRC);
        repeat (16) @(negedge refclk);
        locked = 1'b1;
        t_k = cyc;
        wait_level(1, 1'b0, 100, t_a);
        cmp("bringup_sys_release", t_a - t_k, 12);
        wait_level(2, 1'b0, 100, t_b);
        cmp("bringup_periph_gap", t_b - t_a, 5);
        cmp("bringup_ready", {31'd0, ready}, 1);
        cmp("bringup_retries", {24'd0, retries}, 0);

        // User reset held 7 cycles in RUN
        repeat (3) @(negedge refclk);
        usr_rst_req = 1'b1;
        t_k = cyc;
        wait_level(1, 1'b1, 20, t_a);
        cmp("usr_sys_assert", t_a - t_k, 1);
        cmp("usr_periph_assert", {31'd0, periph_rst}, 1);
        repeat (6) @(negedge refclk);
        usr_rst_req = 1'b0;
        t_k = cyc;
        wait_level(1, 1'b0, 20, t_a);
        cmp("usr_sys_release", t_a - t_k, 1);
        wait_level(2, 1'b0, 20, t_b);
        cmp("usr_periph_gap", t_b - t_a, 5);
        cmp("usr_pll_rst", {31'd0, pll_rst}, 0);
        cmp("usr_lock_lost", {31'd0, lock_lost}, 0);

        // Lock loss in RUN
        repeat (3) @(negedge refclk);
`ifdef PLL_RESET_SEQUENCER_LOSS_FILTER_EN
        locked = 1'b0;
        @(negedge refclk);
        locked = 1'b1;
        repeat (8) @(negedge refclk);
        cmp("glitch_ready", {31'd0, ready}, 1);
        cmp("glitch_lock_lost", {31'd0, lock_lost}, 0);
        locked = 1'b0;
        t_k = cyc;
        repeat (3) @(negedge refclk);
        locked = 1'b1;
`else
        locked = 1'b0;
        t_k = cyc;
        @(negedge refclk);
        locked = 1'b1;
`endif
        wait_level(0, 1'b1, 20, t_a);
        cmp("loss_latency", t_a - t_k, LOSS_LAT);
        cmp("loss_sys_rst", {31'd0, sys_rst}, 1);
        cmp("loss_periph_rst", {31'd0, periph_rst}, 1);
        cmp("loss_ready", {31'd0, ready}, 0);
        cmp("loss_lock_lost", {31'd0, lock_lost}, 1);
        wait_level(3, 1'b1, 200, t_a);

        // Lock held low: loss then two timeouts, 54 cycles apart
        repeat (2) @(negedge refclk);
        locked = 1'b0;
        t_k = cyc;
        prev = pll_rst;
        for (int i = 0; i < 120; i++) begin
            @(negedge refclk);
            if (pll_rst && !prev) rises.push_back(cyc);
            prev = pll_rst;
        end
        cmp("timeout_pulses", rises.size(), 3);
        if (rises.size() >= 3) begin
            cmp("timeout_first", rises[0] - t_k, LOSS_LAT);
            cmp("timeout_period1", rises[1] - rises[0], 54);
            cmp("timeout_period2", rises[2] - rises[1], 54);
        end
        cmp("timeout_retries", {24'd0, retries}, 2);

        // Unstable lock restarts the stability count
        locked = 1'b1;
        repeat (6) @(negedge refclk);
        locked = 1'b0;
        @(negedge refclk);
        locked = 1'b1;
        t_k = cyc;
        wait_level(1, 1'b0, 100, t_a);
        cmp("unstable_sys_release", t_a - t_k, 12);
        cmp("unstable_retries", {24'd0, retries}, 2);
        cmp("unstable_periph_held", {31'd0, periph_rst}, 1);

        // rst while in REL_SYS
        rst = 1'b1;
        @(negedge refclk);
        cmp("midrst_pll_rst", {31'd0, pll_rst}, 1);
        cmp("midrst_sys_rst", {31'd0, sys_rst}, 1);
        cmp("midrst_periph_rst", {31'd0, periph_rst}, 1);
        cmp("midrst_ready", {31'd0, ready}, 0);
        cmp("midrst_lock_lost", {31'd0, lock_lost}, 0);
        cmp("midrst_retries", {24'd0, retries}, 0);
        rst = 1'b0;
        wait_level(3, 1'b1, 100, t_a);
        cmp("final_ready", {31'd0, ready}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the system PLL.
- Runs on the free-running 50 MHz reference clock, which is valid before lock. Drives the PLL's reset input, watches its asynchronous locked output, and releases the core and peripheral resets in order once lock is stable.
- Re-sequences on loss of lock, lock timeout, or a user reset request.

Parameters:
- SYNC_STAGES, 2: flops in the locked synchroniser (min 2).
- PLL_RST_CYCLES, 16: refclk cycles pll_rst is held high per attempt.
- LOCK_TIMEOUT_CYCLES, 1000000: cycles allowed in WAIT_LOCK before retrying the PLL reset (20 ms).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronised-locked cycles required before sys_rst release.
- STAGE_GAP_CYCLES, 256: cycles between sys_rst release and periph_rst release.
- LOSS_FILTER_CYCLES, 8: lock-loss debounce length; used only with the optional feature.
- CNT_W, 20: shared counter width; must hold the largest cycle parameter.

Ports:
- refclk  in  1  50 MHz reference clock; the sole clock.
- rst  in  1  synchronous, active-high reset.
- locked  in  1  PLL locked, asynchronous to refclk.
- usr_rst_req  in  1  synchronous user/OSD reset request, level.
- pll_rst  out  1  to the PLL rst input.
- sys_rst  out  1  core (Z80/VDP) reset, active-high.
- periph_rst  out  1  peripheral reset, active-high.
- ready  out  1  high only in RUN.
- lock_lost  out  1  sticky flag: lock dropped after release; cleared only by rst.
- retries  out  8  count of lock timeouts; saturates at 255; cleared only by rst.

Behaviour:
- Interface: one clock, refclk. rst is synchronous and active-high. All outputs are registered.
- Reset (rst=1 at an edge):
  - state=PLL_RST, cnt=0, synchroniser flops=0.
  - pll_rst=1, sys_rst=1, periph_rst=1, ready=0, lock_lost=0, retries=0.
  - rst overrides every other input in every state.
- lk: locked after SYNC_STAGES flops. Logic uses only lk. Latency from locked to lk is SYNC_STAGES cycles.
- FSM (cnt clears on every state change):
  - PLL_RST: pll_rst=1, all resets 1. After PLL_RST_CYCLES cycles, go to WAIT_LOCK. lk is ignored here.
  - WAIT_LOCK: pll_rst=0, resets 1.
    - lk=1: go to STABLE.
    - Otherwise, when cnt reaches LOCK_TIMEOUT_CYCLES-1: retries+=1 (saturating), go to PLL_RST.
  - STABLE: counts consecutive lk=1 cycles.
    - lk=0: go to WAIT_LOCK; the timeout restarts from 0.
    - At LOCK_STABLE_CYCLES: go to REL_SYS.
  - REL_SYS: sys_rst=0, periph_rst=1. After STAGE_GAP_CYCLES, go to RUN.
  - RUN: sys_rst=0, periph_rst=0, ready=1.
  - USR_HOLD: sys_rst=1, periph_rst=1, pll_rst=0. When usr_rst_req=0, go to REL_SYS, unless lk=0, which takes priority and goes to PLL_RST.
- Lock loss: lk=0 in REL_SYS, RUN or USR_HOLD → lock_lost=1, go to PLL_RST. All resets are reasserted on the next edge.
- User reset: usr_rst_req=1 in REL_SYS or RUN → USR_HOLD.
  - usr_rst_req is ignored in PLL_RST, WAIT_LOCK and STABLE; those states already hold the resets.
  - If lock loss and a user request occur in the same cycle, lock loss wins.
- Ordering guarantees:
  - sys_rst never deasserts while periph_rst is deasserted and sys_rst asserted; periph_rst always releases last and asserts no later than sys_rst.
  - ready=1 implies sys_rst=0 and periph_rst=0.
- Output updates: outputs are decoded from the next state, so output changes coincide with state entry (no extra cycle).

Optional Feature:
- Macro: PLL_RESET_SEQUENCER_LOSS_FILTER_EN.
- Defined: lock loss in REL_SYS, RUN or USR_HOLD needs lk=0 for LOSS_FILTER_CYCLES consecutive cycles before acting. A dedicated filter counter clears whenever lk=1. WAIT_LOCK and STABLE behaviour is unchanged.
- Undefined: a single lk=0 cycle acts immediately. The filter counter and LOSS_FILTER_CYCLES are unused.

Test Plan (sim parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=50, LOCK_STABLE_CYCLES=10, STAGE_GAP_CYCLES=5, LOSS_FILTER_CYCLES=3):
1. Clean bring-up: rst for 3 cycles, locked rising 20 cycles later and held.
   - pll_rst is high for 4 cycles after rst.
   - sys_rst falls exactly 10 cycles after lk rises; periph_rst falls 5 cycles later.
   - ready=1 from then on; retries=0.
2. Timeout: locked held 0 for 120 cycles → pll_rst re-pulses twice (every 54 cycles); retries=2.
3. Unstable lock: locked high 6 cycles, low 1, then high → STABLE restarts; sys_rst falls 10 cycles after the final rise.
4. Loss in RUN: locked low 1 cycle.
   - Without the macro: sys_rst, periph_rst and pll_rst all assert; lock_lost=1; ready=0.
   - With the macro: no effect. A 3-cycle drop triggers the same response.
5. User reset in RUN: usr_rst_req high 7 cycles → both resets assert; on release, sys_rst drops next cycle and periph_rst 5 cycles later; pll_rst stays 0; lock_lost stays 0.
6. Mid-operation rst in REL_SYS: all outputs return to reset values on the next edge; lock_lost and retries clear.
